// File: rtl/and_gate_lib_pkg.sv
// Shared constants for the glue-logic AND gate library cells.
package and_gate_lib_pkg;

    localparam int DELAY_MAX     = 16;
    localparam int DELAY_DEFAULT = 1;

endpackage

// File: rtl/and2_delay_cell.sv
// Single 2-input AND gate with Delay cycles of output latency.
// Delay = 0 gives a combinational path that is forced low during reset.
module and2_delay_cell
    import and_gate_lib_pkg::*;
#(
    parameter int Delay = DELAY_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    output logic y
);

    generate
        if (Delay == 0) begin : g_comb
            assign y = rst ? 1'b0 : (a & b);
        end else begin : g_pipe
            // stages[0] captures the fresh product; y taps the oldest stage.
            logic [Delay-1:0] stages;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    stages <= '0;
                end else begin
                    stages[0] <= a & b;
                    for (int i = 1; i < Delay; i++) begin
                        stages[i] <= stages[i-1];
                    end
                end
            end

            assign y = stages[Delay-1];
        end
    endgenerate

endmodule

// File: rtl/quad_2_input_and_gate.sv
// Four independent 2-input AND gates (74LS08 equivalent) sharing one
// latency setting, clock and asynchronous reset.
module quad_2_input_and_gate
    import and_gate_lib_pkg::*;
#(
    parameter int Delay = DELAY_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic A1,
    input  logic B1,
    input  logic A2,
    input  logic B2,
    input  logic A3,
    input  logic B3,
    input  logic A4,
    input  logic B4,
    output logic Y1,
    output logic Y2,
    output logic Y3,
    output logic Y4
);

    generate
        if (Delay < 0 || Delay > DELAY_MAX) begin : g_bad_delay
            $error("quad_2_input_and_gate: Delay %0d outside 0..%0d", Delay, DELAY_MAX);
        end
    endgenerate

    and2_delay_cell #(.Delay(Delay)) u_gate1 (.clk(clk), .rst(rst), .a(A1), .b(B1), .y(Y1));
    and2_delay_cell #(.Delay(Delay)) u_gate2 (.clk(clk), .rst(rst), .a(A2), .b(B2), .y(Y2));
    and2_delay_cell #(.Delay(Delay)) u_gate3 (.clk(clk), .rst(rst), .a(A3), .b(B3), .y(Y3));
    and2_delay_cell #(.Delay(Delay)) u_gate4 (.clk(clk), .rst(rst), .a(A4), .b(B4), .y(Y4));

endmodule

// File: tb/tb_quad_2_input_and_gate.sv
// Bench for quad_2_input_and_gate: six instances (Delay 0,1,2,3,4,16) share
// inputs; outputs are compared against a history of sampled products.
module tb_quad_2_input_and_gate;

    localparam int NDUT = 6;
    localparam int DLY [NDUT] = '{0, 1, 2, 3, 4, 16};

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] y_all [NDUT];

    int n_cmp = 0;
    int n_err = 0;

    // Products sampled at each post-reset rising edge, newest at index 0.
    logic [3:0] exp_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < NDUT; g++) begin : g_dut
            quad_2_input_and_gate #(.Delay(DLY[g])) u_dut (
                .clk(clk), .rst(rst),
                .A1(a[0]), .B1(b[0]), .A2(a[1]), .B2(b[1]),
                .A3(a[2]), .B3(b[2]), .A4(a[3]), .B4(b[3]),
                .Y1(y_all[g][0]), .Y2(y_all[g][1]),
                .Y3(y_all[g][2]), .Y4(y_all[g][3])
            );
        end
    endgenerate

    // ---------------- reference model ----------------
    always @(posedge clk) begin
        if (rst === 1'b0) begin
            exp_q.push_front(a & b);
            if (exp_q.size() > 17) void'(exp_q.pop_back());
        end
    end

    // Output of a Delay-n gate is the product sampled n-1 edges before the
    // most recent one; zero until n samples exist since reset.
    function automatic logic [3:0] exp_y(int n);
        if (n == 0) return (rst !== 1'b0) ? 4'b0000 : (a & b);
        if (exp_q.size() >= n) return exp_q[n-1];
        return 4'b0000;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(string tag, logic [3:0] obs, logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("%s d%0d", tag, DLY[g]), y_all[g], exp_y(DLY[g]));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(logic [3:0] na, logic [3:0] nb);
        @(negedge clk);
        a = na;
        b = nb;
        #1 check_all("mid");
    endtask

    task automatic step(string tag, logic [3:0] na, logic [3:0] nb);
        drive(na, nb);
        @(posedge clk);
        #1 check_all(tag);
    endtask

    task automatic pulse_reset(string tag);
        #1 rst = 1'b1;
        exp_q.delete();
        #1 check_all({tag, " rst_hi"});
        #1 rst = 1'b0;
        #1 check_all({tag, " rst_lo"});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        a   = 4'hF;
        b   = 4'hF;
        #2 check_all("reset");
        @(negedge clk);
        rst = 1'b0;
        a = 4'h0;
        b = 4'h0;
        #1 check_all("release");

        // Truth-table sweep, one gate at a time, others held at 00.
        for (int g = 0; g < 4; g++) begin
            for (int p = 0; p < 4; p++) begin
                logic [3:0] na;
                logic [3:0] nb;
                na = '0;
                nb = '0;
                na[g] = p[1];
                nb[g] = p[0];
                a = na;
                b = nb;
                #2 check("sweep d0", y_all[0], {2'b00, p[1] & p[0]} << g);
            end
        end
        a = 4'h0;
        b = 4'h0;

        // All 11, then asynchronous reset between edges.
        @(negedge clk);
        a = 4'hF;
        b = 4'hF;
        #1 check("all11 d0", y_all[0], 4'hF);
        pulse_reset("comb");

        // Gate 1 held 11: watch the fill of each pipeline.
        for (int i = 0; i < 5; i++) step("fill", 4'b0001, 4'b0001);

        // Gate 3 pattern 11, 10, 11, 00.
        step("pat3", 4'b0100, 4'b0100);
        step("pat3", 4'b0100, 4'b0000);
        step("pat3", 4'b0100, 4'b0100);
        step("pat3", 4'b0000, 4'b0000);
        for (int i = 0; i < 3; i++) step("pat3 tail", 4'b0000, 4'b0000);

        // Fill with 1s, reset mid-operation, refill.
        for (int i = 0; i < 18; i++) step("full", 4'hF, 4'hF);
        @(negedge clk);
        pulse_reset("mid_op");
        for (int i = 0; i < 6; i++) step("refill", 4'hF, 4'hF);

        // Independent patterns 11, 01, 10, 11.
        step("indep", 4'b1101, 4'b1011);
        step("indep hold", 4'b1101, 4'b1011);

        // Unknown operands: 0 dominates, 1 & x stays unknown.
        step("xprop", 4'b0101, 4'bxxxx);
        step("xprop", 4'b0000, 4'bxxxx);

        // Randomized traffic with occasional reset pulses.
        for (int i = 0; i < 300; i++) begin
            step("rand", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 39) == 0) begin
                @(negedge clk);
                pulse_reset("rand");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/quad_2_input_and_gate.md
Name: quad_2_input_and_gate

Overview:
- Four independent 2-input AND gates, a functional equivalent of a 74LS08.
- Each gate has a parameterised output latency counted in clock cycles: 0 gives a purely combinational path, N delays the output by N cycles.
- Used as a glue-logic library cell in board-level reference designs.

Parameters:
- Delay, default 1, output latency in clk cycles, legal range 0..16. 0 means a combinational output.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- A1  input  1  gate 1 operand A.
- B1  input  1  gate 1 operand B.
- A2  input  1  gate 2 operand A.
- B2  input  1  gate 2 operand B.
- A3  input  1  gate 3 operand A.
- B3  input  1  gate 3 operand B.
- A4  input  1  gate 4 operand A.
- B4  input  1  gate 4 operand B.
- Y1  output  1  A1 AND B1 after the configured latency.
- Y2  output  1  A2 AND B2 after the configured latency.
- Y3  output  1  A3 AND B3 after the configured latency.
- Y4  output  1  A4 AND B4 after the configured latency.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Gates are fully independent. Activity on gate n never affects Y of gate m for m != n.
- Delay = 0:
  - Yn = An & Bn combinationally, no clocked state.
  - While rst = 1, Yn is forced to 0.
- Delay = N > 0:
  - Each gate has an N-stage shift pipeline.
  - Stage 0 captures An & Bn on each rising clk edge.
  - Yn is the last stage, so Yn at edge k+N equals An & Bn sampled at edge k.
  - There is no input or output registering beyond these N stages.
- Reset:
  - rst = 1 asynchronously clears every pipeline stage and drives all Yn = 0 immediately, without waiting for clk.
  - On rst deassertion, outputs stay 0 until valid data has propagated: the first real result appears N edges after the first post-reset sampling edge.
  - Reset mid-operation discards all in-flight values.
- X/Z on inputs propagate per standard AND semantics. A 0 on either input forces 0.
- A Delay outside 0..16 is a elaboration-time error; the design must fail elaboration.
- No handshake and no enable: every clock edge advances the pipeline.

Decomposition:
- Shared package and_gate_lib_pkg:
  - constant DELAY_MAX = 16.
  - constant DELAY_DEFAULT = 1.
- One natural sub-module, and2_delay_cell:
  - Single AND gate with clk, rst, a, b, y and the Delay parameter.
  - Contains the generate branch for combinational vs. pipelined operation.
  - Instantiated four times by quad_2_input_and_gate.
- The top level holds only the parameter range check and the four instances.

Test Plan:
1. Delay=0, rst=0, truth-table sweep of each gate in turn (00, 01, 10, 11 at 2 ns steps, other gates held 00) -> driven gate's Y = 0, 0, 0, 1; all other Y = 0 throughout.
2. Delay=0, all inputs 11 then rst=1 -> Y1..Y4 = 1 with rst low; all = 0 immediately on rst rise; back to 1 on rst fall.
3. Delay=3, A1=B1=1 applied before edge k -> Y1 = 0 at edges k, k+1; Y1 = 1 after edge k+2 (third capturing edge); Y2..Y4 = 0.
4. Delay=2, input pattern on gate 3 of 11, 10, 11, 00 on successive edges -> Y3 reproduces 1, 0, 1, 0 exactly 2 cycles later; no glitches between edges.
5. Delay=4, pipeline full of 1s on all gates, rst pulsed between edges -> all Y = 0 before the next clk edge; after release with inputs still 11, Y = 1 only after 4 edges.
6. Delay=1, simultaneous different patterns on all four gates (11, 01, 10, 11) -> Y1..Y4 = 1, 0, 0, 1 one cycle later, confirming gate independence.
